// File: rtl/rgb_pkg.sv
`default_nettype none
// ============================================================================
// Module : rgb_pkg
// Brief  : Shared types and constants for the RGB command path: FSM state
//          encoding, frame constants and the rgb_t colour triple used by both
//          the parser and the PWM stage.
//          RGB_CMD_CHECKSUM_EN adds the checksum state and a 5-byte frame.
// Rev    : 1.0  initial release
// ============================================================================
package rgb_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hAA;

`ifdef RGB_CMD_CHECKSUM_EN
  localparam int FRAME_LEN = 5;  // SYNC, R, G, B, CS
`else
  localparam int FRAME_LEN = 4;  // SYNC, R, G, B
`endif

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GET_R = 3'd1,
    ST_GET_G = 3'd2,
    ST_GET_B = 3'd3
`ifdef RGB_CMD_CHECKSUM_EN
    ,
    ST_GET_CS = 3'd4
`endif
  } rgb_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Frame checksum: XOR of the three colour bytes.
  function automatic logic [7:0] rgb_csum(input rgb_t c);
    return c.r ^ c.g ^ c.b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rgb_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module : rgb_timeout_cnt
// Brief  : Inter-byte watchdog. Clears on clr, counts while en, and flags
//          expiry once the count reaches TIMEOUT_CYC-1. Holds at the limit
//          until cleared.
// Rev    : 1.0  initial release
// ============================================================================
module rgb_timeout_cnt
  import rgb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 15600
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise count up while enabled and hold at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && (cnt_q == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/rgb_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module : rgb_cmd_parser
// Brief  : Assembles UART bytes into RGB frames, validates them and presents
//          latched 8-bit duty values plus a one-cycle update strobe. Stalled
//          (and, with RGB_CMD_CHECKSUM_EN, bad-checksum) frames are discarded,
//          flagged on frame_err and counted in a saturating err_cnt.
//          Macro RGB_CMD_CHECKSUM_EN: 5-byte frame with XOR checksum byte.
// Rev    : 1.0  initial release
// ============================================================================
module rgb_cmd_parser
  import rgb_pkg::*;
#(
  parameter int         CLK_HZ      = 100_000_000,
  parameter int         BIT_RATE    = 256000,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYC = (CLK_HZ / BIT_RATE) * 10 * 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] duty_r,
  output logic [7:0] duty_g,
  output logic [7:0] duty_b,
  output logic       upd,
  output logic       frame_err,
  output logic [7:0] err_cnt
);

  rgb_state_t state_q, state_d;
  rgb_t       shadow_q, shadow_d;
  rgb_t       duty_q, duty_d;
  logic       upd_q, upd_d;
  logic       frame_err_q, frame_err_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  logic tmo_clr;
  logic tmo_en;
  logic tmo_expired;

  // Watchdog only runs mid-frame; any consumed byte restarts it.
  assign tmo_en  = (state_q != ST_IDLE);
  assign tmo_clr = rx_valid || (state_q == ST_IDLE);

  rgb_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  // Frame FSM: byte capture, commit/discard decisions and error counting.
  // A byte on the expiry cycle takes priority over the timeout.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    duty_d      = duty_q;
    upd_d       = 1'b0;
    frame_err_d = 1'b0;
    err_cnt_d   = err_cnt_q;

    if (rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data == SYNC_BYTE) begin
            state_d = ST_GET_R;
          end
        end
        ST_GET_R: begin
          shadow_d.r = rx_data;
          state_d    = ST_GET_G;
        end
        ST_GET_G: begin
          shadow_d.g = rx_data;
          state_d    = ST_GET_B;
        end
        ST_GET_B: begin
          shadow_d.b = rx_data;
`ifdef RGB_CMD_CHECKSUM_EN
          state_d    = ST_GET_CS;
`else
          duty_d     = shadow_d;
          upd_d      = 1'b1;
          state_d    = ST_IDLE;
`endif
        end
`ifdef RGB_CMD_CHECKSUM_EN
        ST_GET_CS: begin
          if (rx_data == rgb_csum(shadow_q)) begin
            duty_d = shadow_q;
            upd_d  = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
              err_cnt_d = err_cnt_q + 8'd1;
            end
          end
          state_d = ST_IDLE;
        end
`endif
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else if (tmo_expired) begin
      frame_err_d = 1'b1;
      if (err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
      state_d = ST_IDLE;
    end
  end

  // State and output registers; reset drops any partial frame without counting it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shadow_q    <= '0;
      duty_q      <= '0;
      upd_q       <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      duty_q      <= duty_d;
      upd_q       <= upd_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign duty_r    = duty_q.r;
  assign duty_g    = duty_q.g;
  assign duty_b    = duty_q.b;
  assign upd       = upd_q;
  assign frame_err = frame_err_q;
  assign err_cnt   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rgb_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module : tb_rgb_cmd_parser
// Brief  : Scoreboard bench for rgb_cmd_parser. The stimulus process pushes
//          the expected upd / frame_err event for each frame; a monitor pops
//          and compares whenever the DUT raises either strobe. Adapts to the
//          RGB_CMD_CHECKSUM_EN build.
// Rev    : 1.0  initial release
// ============================================================================
module tb_rgb_cmd_parser;

  localparam int         TMO  = 24;
  localparam logic [7:0] SYNC = 8'hAA;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] duty_r, duty_g, duty_b, err_cnt;
  logic       upd, frame_err;

  typedef struct {
    bit         is_err;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];

  int n_checks = 0;
  int n_fails  = 0;

  // Bench-side reference of the latched colour and error count.
  logic [7:0] m_r = 8'h00, m_g = 8'h00, m_b = 8'h00, m_cnt = 8'h00;

  rgb_cmd_parser #(
    .CLK_HZ      (100_000_000),
    .BIT_RATE    (256000),
    .SYNC_BYTE   (SYNC),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .duty_r    (duty_r),
    .duty_g    (duty_g),
    .duty_b    (duty_b),
    .upd       (upd),
    .frame_err (frame_err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One byte: valid for one cycle, then one idle cycle. Starts and ends at a negedge.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic push_upd(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    exp_t e;
    m_r = r; m_g = g; m_b = b;
    e.is_err = 1'b0; e.r = r; e.g = g; e.b = b; e.cnt = m_cnt;
    q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    e.is_err = 1'b1; e.r = m_r; e.g = m_g; e.b = m_b; e.cnt = m_cnt;
    q.push_back(e);
  endtask

  // Well-formed frame; expectation pushed before the final byte.
  task automatic send_frame(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    send(SYNC);
    send(r);
    send(g);
`ifdef RGB_CMD_CHECKSUM_EN
    send(b);
    push_upd(r, g, b);
    send(r ^ g ^ b);
`else
    push_upd(r, g, b);
    send(b);
`endif
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("scoreboard_drain", q.size(), 0);
  endtask

  // Monitor: compare each DUT strobe against the oldest expected event.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (upd || frame_err)) begin
        chk("upd_and_err_exclusive", {31'd0, upd & frame_err}, 0);
        if (q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL unexpected_event: upd=%0b frame_err=%0b duty=%h/%h/%h err_cnt=%0d",
                   upd, frame_err, duty_r, duty_g, duty_b, err_cnt);
        end else begin
          e = q.pop_front();
          chk("event_kind_is_err", {31'd0, frame_err}, {31'd0, e.is_err});
          chk("duty_rgb", {8'd0, duty_r, duty_g, duty_b}, {8'd0, e.r, e.g, e.b});
          chk("err_cnt", {24'd0, err_cnt}, {24'd0, e.cnt});
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_duty", {8'd0, duty_r, duty_g, duty_b}, 0);
    chk("reset_upd", {31'd0, upd}, 0);
    chk("reset_frame_err", {31'd0, frame_err}, 0);
    chk("reset_err_cnt", {24'd0, err_cnt}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic commit.
    send_frame(8'h10, 8'h20, 8'h30);
    wait_drain();

`ifdef RGB_CMD_CHECKSUM_EN
    // Bad checksum: discarded, colour kept.
    send(SYNC); send(8'h10); send(8'h20); send(8'h30);
    push_err();
    send(8'hFF);
`else
    // Without checksum the fourth byte commits; the trailing FF is ignored in IDLE.
    send(SYNC); send(8'h11); send(8'h21);
    push_upd(8'h11, 8'h21, 8'h31);
    send(8'h31);
    send(8'hFF);
`endif
    wait_drain();

    // Leading non-sync byte ignored.
    send(8'h55);
    send_frame(8'h01, 8'h02, 8'h03);
    wait_drain();

    // Stall mid-frame until the watchdog fires, then a normal frame.
    send(SYNC); send(8'h10);
    push_err();
    repeat (TMO + 2) @(negedge clk);
    send_frame(8'h04, 8'h05, 8'h06);
    wait_drain();

    // Byte lands exactly on the expiry cycle: consumed, no error.
    // send() returns two edges after its byte was sampled, so TMO-2 further
    // negedges put the next byte on the TMO-th edge after the previous one.
    send(SYNC); send(8'h11);
    repeat (TMO - 2) @(negedge clk);
    send(8'h22);
`ifdef RGB_CMD_CHECKSUM_EN
    send(8'h33);
    push_upd(8'h11, 8'h22, 8'h33);
    send(8'h00);
`else
    push_upd(8'h11, 8'h22, 8'h33);
    send(8'h33);
`endif
    wait_drain();

    // Saturation of the error counter.
    for (int i = 0; i < 260; i++) begin
      send(SYNC);
      push_err();
      repeat (TMO + 2) @(negedge clk);
    end
    wait_drain();
    chk("err_cnt_saturated", {24'd0, err_cnt}, 32'd255);

    // Reset mid-frame clears everything without counting an error.
    send(SYNC); send(8'h10); send(8'h20);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    m_r = 8'h00; m_g = 8'h00; m_b = 8'h00; m_cnt = 8'h00;
    chk("midreset_duty", {8'd0, duty_r, duty_g, duty_b}, 0);
    chk("midreset_upd", {31'd0, upd}, 0);
    chk("midreset_frame_err", {31'd0, frame_err}, 0);
    chk("midreset_err_cnt", {24'd0, err_cnt}, 0);
    rst = 1'b0;
    @(negedge clk);

    send_frame(8'h01, 8'h01, 8'h01);
    wait_drain();
    send_frame(8'h01, 8'h02, 8'h03);
    wait_drain();
    chk("final_err_cnt", {24'd0, err_cnt}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
